// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared multiply/divide op codes, state type and default
//               cycle counts. Ops 7/8 are decoded only with MULTDIV_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        MD_ST_IDLE = 1'b0,
        MD_ST_RUN  = 1'b1
    } md_state_t;

    // Ops that occupy the unit for a fixed number of cycles.
    function automatic logic md_is_long_op(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MULTDIV_MADD_EN
            MD_MADD, MD_MADDU:                  return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_muldiv_arith.sv
// ============================================================================
// Module      : e_muldiv_arith
// Description : Combinational multiply/divide datapath producing next {HI,LO}
//               and a divide-by-zero flag. MADD/MADDU need MULTDIV_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_muldiv_arith
    import muldiv_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        rs,
    input  logic [31:0]        rt,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [63:0]        result,
    output logic               div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_den_s;
    logic [31:0] w_den_u;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_rt_zero;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign w_prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed division on magnitudes keeps 0x80000000 / -1 well defined.
    assign w_rt_zero = (rt == 32'd0);
    assign w_rs_mag  = rs[31] ? (32'd0 - rs) : rs;
    assign w_rt_mag  = rt[31] ? (32'd0 - rt) : rt;
    assign w_den_s   = w_rt_zero ? 32'd1 : w_rt_mag;
    assign w_den_u   = w_rt_zero ? 32'd1 : rt;
    assign w_q_mag   = w_rs_mag / w_den_s;
    assign w_r_mag   = w_rs_mag % w_den_s;
    assign w_q_s     = (rs[31] ^ rt[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s     = rs[31] ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u     = rs / w_den_u;
    assign w_r_u     = rs % w_den_u;

    always_comb begin
        result      = {hi, lo};
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  result = w_prod_s;
            MD_MULTU: result = w_prod_u;
            MD_DIV: begin
                div_by_zero = w_rt_zero;
                if (!w_rt_zero) result = {w_r_s, w_q_s};
            end
            MD_DIVU: begin
                div_by_zero = w_rt_zero;
                if (!w_rt_zero) result = {w_r_u, w_q_u};
            end
`ifdef MULTDIV_MADD_EN
            MD_MADD:  result = {hi, lo} + w_prod_s;
            MD_MADDU: result = {hi, lo} + w_prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_muldiv.sv
// ============================================================================
// Module      : e_muldiv
// Description : Execute-stage multi-cycle mul/div unit owning HI/LO with a
//               fixed-latency busy counter. Optional MADD/MADDU: MULTDIV_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_muldiv
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] E_md_op,
    input  logic [31:0]        E_rs,
    input  logic [31:0]        E_rt,
    output logic               E_md_start,
    output logic               E_md_busy,
    output logic [31:0]        E_hi,
    output logic [31:0]        E_lo
);

    localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);

    md_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        commit_q, commit_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] w_result;
    logic        w_div_by_zero;

    e_muldiv_arith u_arith (
        .op          (E_md_op),
        .rs          (E_rs),
        .rt          (E_rt),
        .hi          (hi_q),
        .lo          (lo_q),
        .result      (w_result),
        .div_by_zero (w_div_by_zero)
    );

    assign E_md_busy  = (state_q == MD_ST_RUN);
    assign E_md_start = md_is_long_op(E_md_op) && !E_md_busy;
    assign E_hi       = hi_q;
    assign E_lo       = lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MD_ST_IDLE: begin
                if (E_md_start) begin
                    pend_d   = w_result;
                    commit_d = !w_div_by_zero;
                    cnt_d    = md_is_div_op(E_md_op) ? C_DIV_N : C_MULT_N;
                    state_d  = MD_ST_RUN;
                end else if (E_md_op == MD_MTHI) begin
                    hi_d = E_rs;
                end else if (E_md_op == MD_MTLO) begin
                    lo_d = E_rs;
                end
            end
            MD_ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                // Final busy cycle: results become visible after this edge.
                if (cnt_q == 4'd1) begin
                    state_d = MD_ST_IDLE;
                    if (commit_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_ST_IDLE;
            cnt_q    <= 4'd0;
            pend_q   <= 64'd0;
            commit_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_e_muldiv.sv
// ============================================================================
// Module      : tb_e_muldiv
// Description : Self-checking bench for e_muldiv: transaction-level model plus
//               directed vectors. MULTDIV_MADD_EN selects the MADD vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        E_md_start;
    logic        E_md_busy;
    logic [31:0] E_hi;
    logic [31:0] E_lo;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    e_muldiv dut (
        .clk        (clk),
        .reset      (reset),
        .E_md_op    (E_md_op),
        .E_rs       (E_rs),
        .E_rt       (E_rt),
        .E_md_start (E_md_start),
        .E_md_busy  (E_md_busy),
        .E_hi       (E_hi),
        .E_lo       (E_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          m_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_pend = 0;
    bit          m_ok = 0;

    function automatic bit m_long(input logic [3:0] op);
`ifdef MULTDIV_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || op == 4'd7 || op == 4'd8;
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    // Returns {valid, hi, lo} for a long op using plain 64-bit arithmetic.
    function automatic logic [64:0] m_calc(input logic [3:0] op, input logic [31:0] rs,
                                           input logic [31:0] rt, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        acc = {hi, lo};
        case (op)
            4'd1: return {1'b1, 64'(sa * sb)};
            4'd2: return {1'b1, 64'(ua * ub)};
            4'd3: begin
                if (rt == 0) return {1'b0, acc};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            4'd4: begin
                if (rt == 0) return {1'b0, acc};
                return {1'b1, 32'(ua % ub), 32'(ua / ub)};
            end
            4'd7: return {1'b1, acc + 64'(sa * sb)};
            4'd8: return {1'b1, acc + 64'(ua * ub)};
            default: return {1'b0, acc};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= 0;
            m_lo   <= 0;
            m_pend <= 0;
            m_ok   <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_ok) {m_hi, m_lo} <= m_pend;
        end else if (m_long(E_md_op)) begin
            {m_ok, m_pend} <= m_calc(E_md_op, E_rs, E_rt, m_hi, m_lo);
            m_left <= (E_md_op == 4'd3 || E_md_op == 4'd4) ? 10 : 5;
        end else if (E_md_op == 4'd5) begin
            m_hi <= E_rs;
        end else if (E_md_op == 4'd6) begin
            m_lo <= E_rs;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy",  {63'd0, E_md_busy},  {63'd0, (m_left > 0)});
            chk("cyc_start", {63'd0, E_md_start}, {63'd0, (m_long(E_md_op) && m_left == 0)});
            chk("cyc_hi",    {32'd0, E_hi}, {32'd0, m_hi});
            chk("cyc_lo",    {32'd0, E_lo}, {32'd0, m_lo});
        end
    end

    // ---------------- directed stimulus ----------------
    // Presents op for one cycle, then counts busy cycles until idle (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit immediate, output int busy_cycles);
        if (!immediate) begin
            @(posedge clk); #1;
        end
        E_md_op = op; E_rs = rs; E_rt = rt;
        @(posedge clk); #1;
        E_md_op = 4'd0;
        busy_cycles = 0;
        while (E_md_busy && busy_cycles < 40) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int nb;
        reset = 1'b1; E_md_op = 4'd0; E_rs = 32'd0; E_rt = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("reset_busy", {63'd0, E_md_busy}, 64'd0);
        chk("reset_hilo", {E_hi, E_lo}, 64'd0);

        run_op(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, nb);
        chk("mult_busy_cycles", 64'(nb), 64'd5);
        chk("mult_hilo", {E_hi, E_lo}, 64'hFFFFFFFF_FFFFFFFE);

        // Start in the first cycle after completion.
        run_op(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1, nb);
        chk("multu_busy_cycles", 64'(nb), 64'd5);
        chk("multu_hilo", {E_hi, E_lo}, 64'h00000001_FFFFFFFE);

        run_op(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0, nb);
        chk("div_busy_cycles", 64'(nb), 64'd10);
        chk("div_hilo", {E_hi, E_lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(4'd4, 32'h00000007, 32'h00000000, 1'b0, nb);
        chk("divu0_busy_cycles", 64'(nb), 64'd10);
        chk("divu0_hilo", {E_hi, E_lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb);
        chk("div_ovf_hilo", {E_hi, E_lo}, 64'h00000000_80000000);

        run_op(4'd4, 32'd100, 32'd7, 1'b0, nb);
        chk("divu_hilo", {E_hi, E_lo}, {32'd2, 32'd14});

        run_op(4'd5, 32'h12345678, 32'd0, 1'b0, nb);
        chk("mthi_busy_cycles", 64'(nb), 64'd0);
        chk("mthi_hilo", {E_hi, E_lo}, {32'h12345678, 32'd14});

        // MTLO arriving while busy must be dropped.
        @(posedge clk); #1;
        E_md_op = 4'd1; E_rs = 32'h10; E_rt = 32'h10;
        @(posedge clk); #1;
        E_md_op = 4'd0;
        @(posedge clk); #1;
        E_md_op = 4'd6; E_rs = 32'hAAAA0000;
        @(posedge clk); #1;
        E_md_op = 4'd0;
        nb = 0;
        while (E_md_busy && nb < 40) begin
            nb++;
            @(posedge clk); #1;
        end
        chk("mtlo_ignored_hilo", {E_hi, E_lo}, 64'h00000000_00000100);

        run_op(4'd5, 32'hDEADBEEF, 32'd0, 1'b0, nb);

        // Reset during cycle 3 of a MULT aborts it.
        @(posedge clk); #1;
        E_md_op = 4'd1; E_rs = 32'd3; E_rt = 32'd5;
        @(posedge clk); #1;
        E_md_op = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {63'd0, E_md_busy}, 64'd0);
        chk("abort_hilo", {E_hi, E_lo}, 64'd0);

        run_op(4'd2, 32'd3, 32'd4, 1'b0, nb);
        chk("multu_after_abort", {E_hi, E_lo}, 64'd12);

`ifdef MULTDIV_MADD_EN
        run_op(4'd5, 32'd0, 32'd0, 1'b0, nb);
        run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, nb);
        run_op(4'd8, 32'd1, 32'd1, 1'b0, nb);
        chk("maddu_busy_cycles", 64'(nb), 64'd5);
        chk("maddu_hilo", {E_hi, E_lo}, 64'h00000001_00000000);
        run_op(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0, nb);
        chk("madd_hilo", {E_hi, E_lo}, 64'h00000000_FFFFFFFF);
`else
        @(posedge clk); #1;
        E_md_op = 4'd7; E_rs = 32'd9; E_rt = 32'd9;
        #1;
        chk("op7_start", {63'd0, E_md_start}, 64'd0);
        @(posedge clk); #1;
        E_md_op = 4'd0;
        chk("op7_busy", {63'd0, E_md_busy}, 64'd0);
        chk("op7_hilo", {E_hi, E_lo}, 64'd12);
`endif

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
